cdb_arbiter: RTL and testbench

- Arbitrates single-CDB broadcast among functional-unit result producers (alu, mul, div, cmp, ld by default).
- Each requester owns a 1-entry holding buffer, so an FU hands off its result and frees immediately.
- Occupied buffers compete round-robin; the winner is driven onto a registered CDB output consumed by ROB, reservation stations and dispatch operand bypass.
- Flush discards all buffered and in-flight results.

---
 rtl/rv32i_types.sv | 16 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/cdb_arbiter.sv | 82 ++++++++
 tb/tb_cdb_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared result-bus packet type, requester indices and default widths.
package rv32i_types;
    localparam int REQ_ALU = 0;
    localparam int REQ_MUL = 1;
    localparam int REQ_DIV = 2;
    localparam int REQ_CMP = 3;
    localparam int REQ_LD  = 4;
    localparam int N_REQ_DEF = REQ_LD + 1;
    localparam int ROB_IDX_W_DEF = 4;
    localparam int DATA_W_DEF = 32;
    localparam int SRC_W_DEF = $clog2(N_REQ_DEF);
    typedef struct packed {
        logic [ROB_IDX_W_DEF-1:0] dest_rob;
        logic [DATA_W_DEF-1:0]    value;
    } cdb_pkt_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; search starts at ptr and wraps upward.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);
    int j;
    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        grant = '0;
        grant_idx = '0;
        any = |req;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                grant_idx = PW'(j);
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU one-entry holding buffers competing round-robin for a single
// registered common-data-bus broadcast, with flush and a saturating contention counter.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int ROB_IDX_W = ROB_IDX_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SRC_W     = $clog2(N_REQ),
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [N_REQ-1:0]            fu_valid,
    output logic [N_REQ-1:0]            fu_ready,
    input  logic [N_REQ*ROB_IDX_W-1:0]  fu_dest_rob,
    input  logic [N_REQ*DATA_W-1:0]     fu_value,
    output logic                        cdb_valid,
    output logic [ROB_IDX_W-1:0]        cdb_dest_rob,
    output logic [DATA_W-1:0]           cdb_value,
    output logic [SRC_W-1:0]            cdb_src,
    output logic [N_REQ-1:0]            occupancy,
    output logic [CNT_W-1:0]            contention_cnt
);
    typedef struct packed {
        logic [ROB_IDX_W-1:0] dest_rob;
        logic [DATA_W-1:0]    value;
    } pkt_t;

    pkt_t             slot [N_REQ];
    logic [N_REQ-1:0] occ;
    logic [N_REQ-1:0] grant;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] grant_idx;
    logic             any;
    logic             take;

    rr_arbiter #(.N(N_REQ), .PW(SRC_W)) u_arb (
        .req       (occ),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign take      = any && !flush;
    assign fu_ready  = flush ? '0 : (~occ | grant);
    assign occupancy = occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ            <= '0;
            rr_ptr         <= '0;
            cdb_valid      <= 1'b0;
            cdb_dest_rob   <= '0;
            cdb_value      <= '0;
            cdb_src        <= '0;
            contention_cnt <= '0;
            for (int i = 0; i < N_REQ; i++) slot[i] <= '0;
        end else begin
            cdb_valid <= take;
            if ($countones(occ) >= 2 && !flush && contention_cnt != '1)
                contention_cnt <= contention_cnt + 1'b1;
            if (take) begin
                rr_ptr       <= (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                cdb_dest_rob <= slot[grant_idx].dest_rob;
                cdb_value    <= slot[grant_idx].value;
                cdb_src      <= grant_idx;
            end
            // fu_ready is low during flush, so a flush only ever empties slots.
            for (int i = 0; i < N_REQ; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    slot[i] <= {fu_dest_rob[i*ROB_IDX_W +: ROB_IDX_W], fu_value[i*DATA_W +: DATA_W]};
                    occ[i]  <= 1'b1;
                end else if (grant[i] || flush) begin
                    occ[i]  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: cycle table with expected handshake/occupancy/grant order, plus a
// scoreboard matching every broadcast against the results handed to each requester.
module tb_cdb_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic [4:0]   fu_valid = '0;
    logic [4:0]   fu_ready;
    logic [19:0]  fu_dest_rob = '0;
    logic [159:0] fu_value = '0;
    logic         cdb_valid;
    logic [3:0]   cdb_dest_rob;
    logic [31:0]  cdb_value;
    logic [2:0]   cdb_src;
    logic [4:0]   occupancy;
    logic [15:0]  contention_cnt;

    cdb_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .fu_valid       (fu_valid),
        .fu_ready       (fu_ready),
        .fu_dest_rob    (fu_dest_rob),
        .fu_value       (fu_value),
        .cdb_valid      (cdb_valid),
        .cdb_dest_rob   (cdb_dest_rob),
        .cdb_value      (cdb_value),
        .cdb_src        (cdb_src),
        .occupancy      (occupancy),
        .contention_cnt (contention_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  src;
        logic [3:0]  dest;
        logic [31:0] value;
    } exp_t;

    typedef struct {
        logic [4:0]  valid;
        logic        flush;
        logic [3:0]  dest;
        logic [31:0] value;
        logic [4:0]  ready;
        logic [4:0]  occ;
        logic        cv;
        logic [2:0]  src;
        logic [15:0] cnt;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[22];
    int   tests = 0;
    int   fails = 0;
    int   mon_idx;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each broadcast must carry the oldest pending result of the requester it names.
    always @(negedge clk) begin
        if (mon_en && cdb_valid) begin
            mon_idx = -1;
            for (int k = 0; k < sb.size(); k++)
                if (mon_idx < 0 && sb[k].src == cdb_src) mon_idx = k;
            if (mon_idx < 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: src %0d broadcast with no pending result", cdb_src);
            end else begin
                chk("sb_dest", 32'(cdb_dest_rob), 32'(sb[mon_idx].dest));
                chk("sb_value", cdb_value, sb[mon_idx].value);
                sb.delete(mon_idx);
            end
        end
    end

    initial begin
        //           valid  fl dest   value           ready     occ       cv src cnt
        tbl[0]  = '{5'b00100, 0, 4'h7, 32'hDEAD_BEEF, 5'b11111, 5'b00000, 0, 0, 0};
        tbl[1]  = '{5'b00000, 0, 4'h0, 32'h0,         5'b11111, 5'b00100, 0, 0, 0};
        tbl[2]  = '{5'b10000, 0, 4'h3, 32'hA5A5_0000, 5'b11111, 5'b00000, 1, 2, 0};
        tbl[3]  = '{5'b00000, 0, 4'h0, 32'h0,         5'b11111, 5'b10000, 0, 0, 0};
        tbl[4]  = '{5'b11111, 0, 4'h9, 32'h1234_0000, 5'b11111, 5'b00000, 1, 4, 0};
        tbl[5]  = '{5'b00000, 0, 4'h0, 32'h0,         5'b00001, 5'b11111, 0, 0, 0};
        tbl[6]  = '{5'b00000, 0, 4'h0, 32'h0,         5'b00011, 5'b11110, 1, 0, 1};
        tbl[7]  = '{5'b00000, 0, 4'h0, 32'h0,         5'b00111, 5'b11100, 1, 1, 2};
        tbl[8]  = '{5'b00000, 0, 4'h0, 32'h0,         5'b01111, 5'b11000, 1, 2, 3};
        tbl[9]  = '{5'b00000, 0, 4'h0, 32'h0,         5'b11111, 5'b10000, 1, 3, 4};
        tbl[10] = '{5'b00010, 0, 4'h1, 32'h1,         5'b11111, 5'b00000, 1, 4, 4};
        tbl[11] = '{5'b00010, 0, 4'h2, 32'h2,         5'b11111, 5'b00010, 0, 0, 4};
        tbl[12] = '{5'b00010, 0, 4'h3, 32'h3,         5'b11111, 5'b00010, 1, 1, 4};
        tbl[13] = '{5'b00000, 0, 4'h0, 32'h0,         5'b11111, 5'b00010, 1, 1, 4};
        tbl[14] = '{5'b00000, 0, 4'h0, 32'h0,         5'b11111, 5'b00000, 1, 1, 4};
        tbl[15] = '{5'b00111, 0, 4'hC, 32'hC0DE_0000, 5'b11111, 5'b00000, 0, 0, 4};
        tbl[16] = '{5'b10000, 1, 4'hF, 32'hFFFF_FFFF, 5'b00000, 5'b00111, 0, 0, 4};
        tbl[17] = '{5'b00000, 0, 4'h0, 32'h0,         5'b11111, 5'b00000, 0, 0, 4};
        tbl[18] = '{5'b00101, 0, 4'h5, 32'h5555_0000, 5'b11111, 5'b00000, 0, 0, 4};
        tbl[19] = '{5'b00000, 0, 4'h0, 32'h0,         5'b11110, 5'b00101, 0, 0, 4};
        tbl[20] = '{5'b00000, 0, 4'h0, 32'h0,         5'b11111, 5'b00001, 1, 2, 5};
        tbl[21] = '{5'b00000, 0, 4'h0, 32'h0,         5'b11111, 5'b00000, 1, 0, 5};

        #1 rst = 1'b1;
        #1;
        chk("rst_cdb_valid", 32'(cdb_valid), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_cnt", 32'(contention_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", 32'(fu_ready), 32'h1F);

        mon_en = 1'b1;
        for (int r = 0; r < 22; r++) begin
            fu_valid = tbl[r].valid;
            flush = tbl[r].flush;
            for (int i = 0; i < 5; i++) begin
                fu_dest_rob[i*4 +: 4] = tbl[r].dest + 4'(i);
                fu_value[i*32 +: 32] = tbl[r].value + (32'(i) << 24);
                if (tbl[r].valid[i] && tbl[r].ready[i] && !tbl[r].flush)
                    sb.push_back('{3'(i), tbl[r].dest + 4'(i), tbl[r].value + (32'(i) << 24)});
            end
            @(negedge clk);
            chk($sformatf("r%0d_ready", r), 32'(fu_ready), 32'(tbl[r].ready));
            chk($sformatf("r%0d_occ", r), 32'(occupancy), 32'(tbl[r].occ));
            chk($sformatf("r%0d_cdb_valid", r), 32'(cdb_valid), 32'(tbl[r].cv));
            if (tbl[r].cv) chk($sformatf("r%0d_cdb_src", r), 32'(cdb_src), 32'(tbl[r].src));
            chk($sformatf("r%0d_cnt", r), 32'(contention_cnt), 32'(tbl[r].cnt));
            @(posedge clk);
            #1;
            if (tbl[r].flush) sb.delete();
        end
        fu_valid = '0;
        flush = 1'b0;
        chk("sb_drained", sb.size(), 0);
        mon_en = 1'b0;

        // Two requesters refilling every cycle keep at least two slots occupied.
        fu_valid = 5'b00011;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_cnt", 32'(contention_cnt), 32'hFFFF);
        fu_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", 32'(contention_cnt), 32'hFFFF);
        chk("sat_drained", 32'(occupancy), 0);

        fu_valid = 5'b00010;
        @(posedge clk);
        #1 fu_valid = 5'b10110;
        @(posedge clk);
        #1 fu_valid = '0;
        #1;
        chk("pre_rst_occ", 32'(occupancy), 32'h16);
        chk("pre_rst_cdb_valid", 32'(cdb_valid), 1);
        rst = 1'b1;
        #1;
        chk("arst_occ", 32'(occupancy), 0);
        chk("arst_cdb_valid", 32'(cdb_valid), 0);
        chk("arst_dest", 32'(cdb_dest_rob), 0);
        chk("arst_value", cdb_value, 0);
        chk("arst_src", 32'(cdb_src), 0);
        chk("arst_cnt", 32'(contention_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("arst_ready", 32'(fu_ready), 32'h1F);
        fu_valid = 5'b00110;
        @(posedge clk);
        #1 fu_valid = '0;
        @(posedge clk);
        #1;
        chk("arst_ptr_first_valid", 32'(cdb_valid), 1);
        chk("arst_ptr_first_src", 32'(cdb_src), 1);
        @(posedge clk);
        #1;
        chk("arst_ptr_second_src", 32'(cdb_src), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
